// File: rtl/popcount_pkg.sv
// rtl/popcount_pkg.sv - shared widths, helper functions and mode type for popcount_stream
package popcount_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width needed to hold a count of 0..lane_w set bits.
    function automatic int lane_cnt_w(input int lane_w);
        return clog2(lane_w + 1);
    endfunction

    function automatic int beat_sum_w(input int data_w);
        return clog2(data_w + 1);
    endfunction

    typedef enum logic {
        CNT_ONES  = 1'b0,
        CNT_ZEROS = 1'b1
    } cnt_mode_e;

endpackage

// File: rtl/popcount_lane.sv
// rtl/popcount_lane.sv - combinational ones count of one LANE_W-bit lane
module popcount_lane
    import popcount_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int CNT_W  = lane_cnt_w(LANE_W)
) (
    input  logic [LANE_W-1:0] data_i,
    output logic [CNT_W-1:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < LANE_W; i++) begin
            count_o = count_o + CNT_W'(data_i[i]);
        end
    end

endmodule

// File: rtl/popcount_stream.sv
// rtl/popcount_stream.sv - streaming packet popcount; define POPCOUNT_SAT_EN for saturating counters
module popcount_stream
    import popcount_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LANE_W = 8,
    parameter int ACC_W  = 16,
    parameter int BEAT_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_mode,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_count,
    output logic [BEAT_W-1:0] out_beats,
    output logic              out_ovf
);

    localparam int N_LANES = DATA_W / LANE_W;
    localparam int CNT_W   = lane_cnt_w(LANE_W);
    localparam int SUM_W   = beat_sum_w(DATA_W);
    localparam int ACC_X   = ACC_W + 1;
    localparam int BEAT_X  = BEAT_W + 1;

    logic              stall;
    logic              accept;
    cnt_mode_e         mode;
    logic [DATA_W-1:0] lane_data;
    logic [CNT_W-1:0]  lane_cnt [N_LANES];

    logic [CNT_W-1:0]  s1_cnt_q [N_LANES];
    logic [CNT_W-1:0]  s1_cnt_d [N_LANES];
    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q,  s1_last_d;
    logic [ACC_W-1:0]  acc_q,      acc_d;
    logic [BEAT_W-1:0] beats_q,    beats_d;
    logic              ovf_q,      ovf_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_count_q, out_count_d;
    logic [BEAT_W-1:0] out_beats_q, out_beats_d;
    logic              out_ovf_q,   out_ovf_d;

    logic [SUM_W-1:0]  beat_sum;
    logic [ACC_W:0]    acc_sum;
    logic [BEAT_W:0]   beats_sum;
    logic [ACC_W-1:0]  acc_next;
    logic [BEAT_W-1:0] beats_next;
    logic              ovf_next;

    assign stall     = out_valid_q && !out_ready;
    assign accept    = in_valid && !stall;
    assign in_ready  = !stall;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_beats = out_beats_q;
    assign out_ovf   = out_ovf_q;

    assign mode      = cnt_mode_e'(in_mode);
    assign lane_data = (mode == CNT_ZEROS) ? ~in_data : in_data;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        popcount_lane #(
            .LANE_W (LANE_W),
            .CNT_W  (CNT_W)
        ) u_lane (
            .data_i  (lane_data[g*LANE_W +: LANE_W]),
            .count_o (lane_cnt[g])
        );
    end

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < N_LANES; i++) begin
            beat_sum = beat_sum + SUM_W'(s1_cnt_q[i]);
        end
        acc_sum   = {1'b0, acc_q} + ACC_X'(beat_sum);
        beats_sum = {1'b0, beats_q} + BEAT_X'(1);
`ifdef POPCOUNT_SAT_EN
        acc_next   = acc_sum[ACC_W]    ? '1 : acc_sum[ACC_W-1:0];
        beats_next = beats_sum[BEAT_W] ? '1 : beats_sum[BEAT_W-1:0];
`else
        acc_next   = acc_sum[ACC_W-1:0];
        beats_next = beats_sum[BEAT_W-1:0];
`endif
        ovf_next = ovf_q | acc_sum[ACC_W] | beats_sum[BEAT_W];
    end

    always_comb begin
        s1_cnt_d    = s1_cnt_q;
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_cnt_d  = lane_cnt;
                s1_last_d = in_last;
            end
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    // Result load wins over a same-cycle consumer accept.
                    out_valid_d = 1'b1;
                    out_count_d = acc_next;
                    out_beats_d = beats_next;
                    out_ovf_d   = ovf_next;
                    acc_d       = '0;
                    beats_d     = '0;
                    ovf_d       = 1'b0;
                end else begin
                    acc_d   = acc_next;
                    beats_d = beats_next;
                    ovf_d   = ovf_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LANES; i++) begin
                s1_cnt_q[i] <= '0;
            end
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            beats_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_cnt_q    <= s1_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_popcount_stream.sv
// tb/tb_popcount_stream.sv - self-checking bench for popcount_stream (wrap or POPCOUNT_SAT_EN build)
module tb_popcount_stream;

    localparam int DATA_W = 64;
    localparam int ACC_W  = 16;
    localparam int BEAT_W = 12;
    localparam longint ACC_MAX  = (longint'(1) << ACC_W) - 1;
    localparam longint BEAT_MAX = (longint'(1) << BEAT_W) - 1;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_mode;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_count;
    logic [BEAT_W-1:0] out_beats;
    logic              out_ovf;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_acc_cyc;
    bit rnd_done;

    logic [ACC_W-1:0]  obs_cnt[$];
    logic [BEAT_W-1:0] obs_bts[$];
    logic              obs_ovf[$];
    int                obs_cyc[$];
    logic [ACC_W-1:0]  exp_cnt[$];
    logic [BEAT_W-1:0] exp_bts[$];
    logic              exp_ovf[$];

    popcount_stream #(
        .DATA_W (DATA_W),
        .LANE_W (8),
        .ACC_W  (ACC_W),
        .BEAT_W (BEAT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_beats (out_beats),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            obs_cnt.push_back(out_count);
            obs_bts.push_back(out_beats);
            obs_ovf.push_back(out_ovf);
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exhausted, want completion");
        $fatal(1, "watchdog");
    end

    function automatic void model(input logic [63:0] d[$], input bit m[$],
                                  output logic [ACC_W-1:0] c, output logic [BEAT_W-1:0] b,
                                  output logic o);
        longint total = 0;
        longint n     = longint'(d.size());
        foreach (d[i]) total += longint'($countones(m[i] ? ~d[i] : d[i]));
        o = (total > ACC_MAX) || (n > BEAT_MAX);
`ifdef POPCOUNT_SAT_EN
        c = ACC_W'((total > ACC_MAX) ? ACC_MAX : total);
        b = BEAT_W'((n > BEAT_MAX) ? BEAT_MAX : n);
`else
        c = ACC_W'(total);
        b = BEAT_W'(n);
`endif
    endfunction

    task automatic clear_queues();
        obs_cnt.delete(); obs_bts.delete(); obs_ovf.delete(); obs_cyc.delete();
        exp_cnt.delete(); exp_bts.delete(); exp_ovf.delete();
    endtask

    task automatic drive_beat(input logic [63:0] d, input bit m, input bit l, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waited);
        end
        last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] d[$], input bit m[$], output int stalls);
        logic [ACC_W-1:0]  c;
        logic [BEAT_W-1:0] b;
        logic              o;
        int                w;
        model(d, m, c, b, o);
        exp_cnt.push_back(c); exp_bts.push_back(b); exp_ovf.push_back(o);
        stalls = 0;
        foreach (d[i]) begin
            drive_beat(d[i], m[i], i == d.size() - 1, w);
            stalls += w;
        end
    endtask

    task automatic wait_results(input int n);
        int g = 0;
        while (obs_cnt.size() < n && g < 2000) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (obs_cnt.size() < n) begin
            n_cmp++; n_fail++;
            $display("FAIL result_timeout: got %0d results, want %0d", obs_cnt.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_count !== '0)   begin n_fail++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
        n_cmp++; if (out_beats !== '0)   begin n_fail++; $display("FAIL reset_out_beats: got %0d want 0", out_beats); end
        n_cmp++; if (out_ovf !== 1'b0)   begin n_fail++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_single();
        int w;
        int acc_cyc;
        clear_queues();
        drive_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, w);
        acc_cyc = last_acc_cyc;
        wait_results(1);
        if (obs_cnt.size() >= 1) begin
            n_cmp++; if (obs_cnt[0] !== 16'd64) begin n_fail++; $display("FAIL single_count: got %0d want 64", obs_cnt[0]); end
            n_cmp++; if (obs_bts[0] !== 12'd1)  begin n_fail++; $display("FAIL single_beats: got %0d want 1", obs_bts[0]); end
            n_cmp++; if (obs_ovf[0] !== 1'b0)   begin n_fail++; $display("FAIL single_ovf: got %b want 0", obs_ovf[0]); end
            n_cmp++; if (obs_cyc[0] !== acc_cyc + 2) begin
                n_fail++; $display("FAIL single_latency: got cycle %0d want %0d", obs_cyc[0], acc_cyc + 2);
            end
        end
    endtask

    task automatic test_multi();
        int w;
        clear_queues();
        drive_beat(64'h1,  1'b0, 1'b0, w);
        drive_beat(64'h3,  1'b1, 1'b0, w);
        drive_beat(64'hF0, 1'b0, 1'b1, w);
        wait_results(1);
        if (obs_cnt.size() >= 1) begin
            n_cmp++; if (obs_cnt[0] !== 16'd67) begin n_fail++; $display("FAIL multi_count: got %0d want 67", obs_cnt[0]); end
            n_cmp++; if (obs_bts[0] !== 12'd3)  begin n_fail++; $display("FAIL multi_beats: got %0d want 3", obs_bts[0]); end
            n_cmp++; if (obs_ovf[0] !== 1'b0)   begin n_fail++; $display("FAIL multi_ovf: got %b want 0", obs_ovf[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int w0, w1, c0;
        clear_queues();
        drive_beat(64'h0,  1'b0, 1'b1, w0);
        c0 = last_acc_cyc;
        drive_beat(64'hFF, 1'b0, 1'b1, w1);
        n_cmp++; if (w0 != 0 || w1 != 0 || last_acc_cyc != c0 + 1) begin
            n_fail++; $display("FAIL b2b_in_ready: stalls %0d/%0d accept gap %0d, want 0/0 gap 1", w0, w1, last_acc_cyc - c0);
        end
        wait_results(2);
        if (obs_cnt.size() >= 2) begin
            n_cmp++; if (obs_cnt[0] !== 16'd0) begin n_fail++; $display("FAIL b2b_count0: got %0d want 0", obs_cnt[0]); end
            n_cmp++; if (obs_cnt[1] !== 16'd8) begin n_fail++; $display("FAIL b2b_count1: got %0d want 8", obs_cnt[1]); end
            n_cmp++; if (obs_cyc[1] !== obs_cyc[0] + 1) begin
                n_fail++; $display("FAIL b2b_spacing: got gap %0d want 1", obs_cyc[1] - obs_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0]      d1[$];
        logic [63:0]      d2[$];
        bit               m1[$];
        bit               m2[$];
        logic [ACC_W-1:0] hold;
        int               s;
        clear_queues();
        d1.push_back({$urandom, $urandom}); m1.push_back(1'($urandom));
        for (int i = 0; i < 3; i++) begin
            d2.push_back({$urandom, $urandom}); m2.push_back(1'($urandom));
        end
        out_ready = 1'b0;
        fork
            begin
                send_pkt(d1, m1, s);
                send_pkt(d2, m2, s);
            end
            begin
                int g = 0;
                @(negedge clk);
                while (!out_valid && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                hold = out_count;
                n_cmp++; if (hold !== exp_cnt[0]) begin
                    n_fail++; $display("FAIL bp_pending_count: got %0d want %0d", hold, exp_cnt[0]);
                end
                for (int k = 0; k < 5; k++) begin
                    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_count !== hold) begin
                        n_fail++;
                        $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b count=%0d want 0/1/%0d",
                                 k, in_ready, out_valid, out_count, hold);
                    end
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_results(2);
        for (int i = 0; i < 2 && i < obs_cnt.size(); i++) begin
            n_cmp++; if (obs_cnt[i] !== exp_cnt[i] || obs_bts[i] !== exp_bts[i] || obs_ovf[i] !== exp_ovf[i]) begin
                n_fail++;
                $display("FAIL bp_result%0d: got %0d/%0d/%b want %0d/%0d/%b", i,
                         obs_cnt[i], obs_bts[i], obs_ovf[i], exp_cnt[i], exp_bts[i], exp_ovf[i]);
            end
        end
    endtask

    task automatic test_random();
        int s;
        clear_queues();
        rnd_done = 1'b0;
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join_none
        for (int p = 0; p < 20; p++) begin
            logic [63:0] d[$];
            bit          m[$];
            int          len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                case ($urandom_range(0, 5))
                    0:       d.push_back('0);
                    1:       d.push_back('1);
                    default: d.push_back({$urandom, $urandom});
                endcase
                m.push_back(1'($urandom));
            end
            send_pkt(d, m, s);
        end
        rnd_done = 1'b1;
        wait_results(20);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && i < obs_cnt.size(); i++) begin
            n_cmp++; if (obs_cnt[i] !== exp_cnt[i] || obs_bts[i] !== exp_bts[i] || obs_ovf[i] !== exp_ovf[i]) begin
                n_fail++;
                $display("FAIL random_result%0d: got %0d/%0d/%b want %0d/%0d/%b", i,
                         obs_cnt[i], obs_bts[i], obs_ovf[i], exp_cnt[i], exp_bts[i], exp_ovf[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] d[$];
        bit          m[$];
        int          s;
        clear_queues();
        for (int i = 0; i < 1025; i++) begin d.push_back('1); m.push_back(1'b0); end
        send_pkt(d, m, s);
        d.delete(); m.delete();
        for (int i = 0; i < 4097; i++) begin d.push_back('0); m.push_back(1'b0); end
        send_pkt(d, m, s);
        wait_results(2);
        for (int i = 0; i < 2 && i < obs_cnt.size(); i++) begin
            n_cmp++; if (obs_cnt[i] !== exp_cnt[i] || obs_bts[i] !== exp_bts[i]) begin
                n_fail++;
                $display("FAIL ovf_result%0d: got %0d/%0d want %0d/%0d", i,
                         obs_cnt[i], obs_bts[i], exp_cnt[i], exp_bts[i]);
            end
            n_cmp++; if (obs_ovf[i] !== 1'b1) begin
                n_fail++; $display("FAIL ovf_flag%0d: got %b want 1", i, obs_ovf[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        clear_queues();
        drive_beat({$urandom, $urandom}, 1'b0, 1'b0, w);
        drive_beat({$urandom, $urandom}, 1'b1, 1'b0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_beat(64'h7, 1'b0, 1'b1, w);
        wait_results(1);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (obs_cnt.size() != 1) begin
            n_fail++; $display("FAIL rstmid_result_count: got %0d results want 1", obs_cnt.size());
        end
        if (obs_cnt.size() >= 1) begin
            n_cmp++; if (obs_cnt[0] !== 16'd3) begin n_fail++; $display("FAIL rstmid_count: got %0d want 3", obs_cnt[0]); end
            n_cmp++; if (obs_bts[0] !== 12'd1) begin n_fail++; $display("FAIL rstmid_beats: got %0d want 1", obs_bts[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/popcount_stream.md
# popcount_stream

Streaming, parametrised successor to the single-word ones counter. Accepts packets as a sequence of DATA_W-bit beats over a valid/ready handshake, counts ones (or zeros, per beat) in a two-stage pipeline, and accumulates across beats. On the last beat it emits one packet-total result plus the packet's beat count. It sits between the packet source and the statistics/checksum logic, and replaces ad-hoc per-word counters wherever packets span several words.

## Interface
- DATA_W, 64, beat width in bits; a multiple of LANE_W.
- LANE_W, 8, bits counted per lane in stage 1.
- ACC_W, 16, width of the packet-total accumulator and out_count.
- BEAT_W, 12, width of the beat counter and out_beats.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  beat present.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_data  input  DATA_W  beat data.
- in_mode  input  1  0 = count ones, 1 = count zeros (per beat).
- in_last  input  1  final beat of the packet.
- out_valid  output  1  result present; held until accepted.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_count  output  ACC_W  packet total.
- out_beats  output  BEAT_W  number of beats in the packet.
- out_ovf  output  1  accumulator or beat counter exceeded its width during the packet.

## Operation
- stall = out_valid && !out_ready; in_ready = !stall; the whole pipeline freezes while stall is high.
- Stage 1, on an accepted beat:
  - Register DATA_W/LANE_W lane counts, each of width clog2(LANE_W+1); in_mode inverts the lane data before counting.
  - Register s1_valid and s1_last.
  - When there is no accepted beat and no stall, s1_valid clears.
- Stage 2, when s1_valid && !stall:
  - beat_sum = sum of lane counts; width clog2(DATA_W+1).
  - acc += beat_sum; beats += 1.
  - When s1_last: load out_count = acc + beat_sum and out_beats = beats + 1; set out_valid; clear acc and beats to 0 in the same cycle so the next packet starts clean.
- out_valid clears on out_valid && out_ready unless a new result loads in that same cycle. The new result takes priority and out_valid stays 1.
- Single-beat packet (first beat has in_last): out_beats = 1.
- No idle FSM. The states are implicit: IDLE (acc=0, beats=0), ACCUM (nonzero partial), HOLD (stall).
- Overflow sets sticky ovf_r for the current packet. out_ovf is loaded with it, and it clears when acc clears. Wrap/saturate behaviour is set under Configuration.

## Timing
- Reset values: in_ready=1, out_valid=0, out_count=0, out_beats=0, out_ovf=0, s1_valid=0, acc=0, beats=0.
- Latency: last beat accepted in cycle N gives out_valid=1 in cycle N+2.
- Throughput: one beat per cycle with no bubbles while out_ready=1, including back-to-back packets.
- Backpressure: at most one result is buffered. Further beats are refused (in_ready=0) until the result is taken.
- out_count, out_beats and out_ovf are stable while out_valid && !out_ready.
- Reset asserted mid-packet drops the partial packet and any pending result. The first cycle after reset deasserts behaves as after power-up.

## Configuration
- POPCOUNT_SAT_EN defined: acc saturates at 2^ACC_W-1 and beats at 2^BEAT_W-1; out_ovf reports saturation.
- POPCOUNT_SAT_EN undefined: both counters wrap modulo 2^width; out_ovf still reports the carry out.

## Structure
- popcount_pkg holds:
  - function clog2;
  - localparam-style helpers for lane-count width and beat-sum width;
  - typedef enum logic {CNT_ONES, CNT_ZEROS} cnt_mode_e.
- Sub-module popcount_lane: combinational, LANE_W-bit input giving its ones count. It is instantiated DATA_W/LANE_W times via generate in stage 1.
- Top-level holds the stall logic, the pipeline registers, the accumulator and the output register.

## Test plan
- Single beat 64'hFFFF_FFFF_FFFF_FFFF, mode 0, last, out_ready=1 -> out_count=64, out_beats=1, out_ovf=0, out_valid at N+2.
- Three beats 64'h1, 64'h3, 64'hF0 with modes 0, 1, 0, last on the third -> out_count=1+62+4=67, out_beats=3.
- Back-to-back single-beat packets 64'h0 and 64'hFF every cycle, out_ready=1 -> results 0 then 8 on consecutive cycles, in_ready never drops.
- Hold out_ready=0 for 5 cycles with a result pending while a second packet streams in -> in_ready=0 from the stall cycle, out_count stable, and no beat lost after release.
- ACC_W=8, five beats of all ones -> saturating build: out_count=255, out_ovf=1; wrapping build: out_count=64 (320 mod 256), out_ovf=1.
- Assert rst for one cycle after two beats of a packet, then send 64'h7 last -> out_count=3, out_beats=1.
